hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline interlock controller for the 5-stage RV32 core. Sits beside the EX-stage operand forwarding mux.
- Resolves the hazards forwarding cannot fix: load-use, multi-cycle MUL/DIV in EX, data-memory wait, taken branch/jump.
- Drives per-stage stall, bubble and flush strobes, and sequences the MDU start/done handshake.

Parameters:
MDU_TIMEOUT, 64, cycles in MDU_WAIT before mdu_err is raised
CNT_W, 16, width of the performance counters (used only with HAZARD_PERF_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of the instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_mdu_valid  in  1  EX instruction is MUL/DIV
ex_branch_taken  in  1  EX redirects the PC
mdu_done  in  1  MDU result valid, single-cycle pulse
mem_wait  in  1  data memory not ready for the MEM-stage access
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  IF/ID becomes NOP
id_ex_stall  out  1  hold ID/EX
id_ex_bubble  out  1  ID/EX loads NOP
ex_mem_stall  out  1  hold EX/MEM
ex_mem_bubble  out  1  EX/MEM loads NOP
mem_wb_bubble  out  1  MEM/WB loads NOP
pc_redirect  out  1  PC takes the branch target
mdu_start  out  1  one-cycle MDU launch
mdu_err  out  1  MDU timeout flag, sticky until reset

Behaviour:
- Clocking and reset: single clock domain, clk; asynchronous active-high reset, rst.
- While rst=1: state=RUN, done_seen=0, wait_cnt=0, mdu_err=0, and every output is forced to 0.
- All strobes are combinational from state, registered flags and current inputs, so they take effect in the same cycle; zero latency.
- FSM states: RUN, MDU_WAIT.
- RUN, first matching rule wins:
  1. mem_wait=1: pc_stall, if_id_stall, id_ex_stall and ex_mem_stall =1; mem_wb_bubble=1. No flush, redirect or mdu_start. State holds.
  2. ex_mdu_valid=1: mdu_start=1; pc_stall, if_id_stall and id_ex_stall =1; ex_mem_bubble=1. Next state MDU_WAIT; wait_cnt cleared.
  3. ex_branch_taken=1: pc_redirect=1, if_id_flush=1, id_ex_bubble=1. A load-use match in the same cycle is ignored because the ID instruction is killed.
  4. Load-use (ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))): pc_stall=1, if_id_stall=1, id_ex_bubble=1. This is a single-cycle stall; the next cycle resolves via the MEM-stage forward.
  5. Otherwise all outputs are 0.
- ex_mdu_valid and ex_branch_taken are mutually exclusive by ISA decode; the bench asserts this.
- MDU_WAIT:
  - wait_cnt increments each cycle, saturating at MDU_TIMEOUT.
  - When wait_cnt reaches MDU_TIMEOUT, mdu_err is set and stays set; the FSM keeps waiting.
  - mdu_done with mem_wait=1: done_seen is set and the full freeze of RUN rule 1 is applied.
  - mem_wait=1 without done: full freeze as in RUN rule 1.
  - (mdu_done or done_seen) with mem_wait=0: release cycle. All stalls are 0, so EX/MEM captures the MDU result. done_seen is cleared; next state RUN.
  - Otherwise: pc_stall, if_id_stall and id_ex_stall =1; ex_mem_bubble=1.
  - ex_mdu_valid and ex_branch_taken are ignored in MDU_WAIT.
  - mdu_start is never asserted in MDU_WAIT.
- mdu_done arriving in RUN is ignored; it does not set done_seen.
- A branch in EX under mem_wait is not lost: EX is frozen, so ex_branch_taken is re-presented on the next unfrozen cycle.
- Reset mid-MDU_WAIT: returns to RUN immediately; the MDU is expected to be reset by the same rst.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cycles [CNT_W], perf_flushes [CNT_W] and perf_loaduse [CNT_W], all 0 on reset.
  - perf_stall_cycles increments on every cycle with pc_stall=1.
  - perf_flushes increments on every cycle with if_id_flush=1.
  - perf_loaduse increments on every cycle where RUN rule 4 fires.
  - All three counters saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → exactly 1 cycle of pc_stall=1, if_id_stall=1, id_ex_bubble=1. With ex_rd=0 → no stall.
- MDU: ex_mdu_valid=1 → mdu_start=1 for 1 cycle; 6 stall cycles; mdu_done on the 6th cycle → release that cycle; RUN next cycle; mdu_err=0.
- MDU done under mem_wait: mdu_done pulses while mem_wait=1 (cycles 3-5) → done_seen set; release on the first cycle with mem_wait=0; no mdu_start re-issue.
- Branch plus load-use in the same cycle: pc_redirect=1, if_id_flush=1, id_ex_bubble=1, pc_stall=0. Branch with mem_wait=1 → frozen, redirect only once mem_wait=0.
- Timeout: hold mdu_done=0 for 70 cycles → mdu_err rises after 64 cycles in MDU_WAIT and stays high; rst clears it and forces all outputs to 0 asynchronously.
- With HAZARD_PERF_EN: 3 load-use events plus one 6-cycle MDU op → perf_loaduse=3, perf_stall_cycles=9.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline interlock controller for the 5-stage RV32 core. Handles
//            the hazards operand forwarding cannot fix: load-use, multi-cycle
//            MUL/DIV in EX, data-memory wait and taken branch/jump. Drives
//            per-stage stall/bubble/flush strobes and the MDU start/done
//            handshake.
// Ports    : clk, rst (async, active-high)
//            ID/EX hazard inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2,
//                                  ex_rd, ex_is_load, ex_mdu_valid,
//                                  ex_branch_taken
//            MDU / memory        : mdu_done, mem_wait
//            Strobes (comb)      : pc_stall, if_id_stall, if_id_flush,
//                                  id_ex_stall, id_ex_bubble, ex_mem_stall,
//                                  ex_mem_bubble, mem_wb_bubble, pc_redirect,
//                                  mdu_start
//            Status (reg)        : mdu_err (sticky timeout flag)
// Options  : `define HAZARD_PERF_EN adds saturating performance counters
//            perf_stall_cycles, perf_flushes, perf_loaduse (CNT_W bits).
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mdu_valid,
  input  logic             ex_branch_taken,
  input  logic             mdu_done,
  input  logic             mem_wait,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_stall,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             pc_redirect,
  output logic             mdu_start,
  output logic             mdu_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes,
  output logic [CNT_W-1:0] perf_loaduse
`endif
);

  localparam int                c_WCNT_W = $clog2(MDU_TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0] c_TMO  = c_WCNT_W'(MDU_TIMEOUT);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MDU_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_done_seen;
  logic [c_WCNT_W-1:0] r_wait_cnt;
  logic                r_err;

  logic w_load_use;
  logic w_lu_fire;
  logic w_release;
  logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall;
  logic w_id_ex_bubble, w_ex_mem_stall, w_ex_mem_bubble, w_mem_wb_bubble;
  logic w_pc_redirect, w_mdu_start;
  logic [c_WCNT_W-1:0] w_cnt_nxt;

  assign w_load_use = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

  assign w_cnt_nxt = (r_wait_cnt == c_TMO) ? r_wait_cnt : r_wait_cnt + 1'b1;

  // Strobes are pure combinational decode; rst gates them all to zero.
  always_comb begin
    w_pc_stall      = 1'b0;
    w_if_id_stall   = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_stall   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_stall  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_pc_redirect   = 1'b0;
    w_mdu_start     = 1'b0;
    w_lu_fire       = 1'b0;
    w_release       = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        // Full freeze: everything up to EX/MEM holds, WB gets a bubble.
        w_pc_stall      = 1'b1;
        w_if_id_stall   = 1'b1;
        w_id_ex_stall   = 1'b1;
        w_ex_mem_stall  = 1'b1;
        w_mem_wb_bubble = 1'b1;
      end else if (r_state == S_MDU_WAIT) begin
        if (mdu_done || r_done_seen) begin
          // Release cycle: no stalls so EX/MEM captures the MDU result.
          w_release = 1'b1;
        end else begin
          w_pc_stall      = 1'b1;
          w_if_id_stall   = 1'b1;
          w_id_ex_stall   = 1'b1;
          w_ex_mem_bubble = 1'b1;
        end
      end else if (ex_mdu_valid) begin
        w_mdu_start     = 1'b1;
        w_pc_stall      = 1'b1;
        w_if_id_stall   = 1'b1;
        w_id_ex_stall   = 1'b1;
        w_ex_mem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        // The ID instruction is killed, so a coincident load-use is moot.
        w_pc_redirect  = 1'b1;
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if (w_load_use) begin
        w_lu_fire      = 1'b1;
        w_pc_stall     = 1'b1;
        w_if_id_stall  = 1'b1;
        w_id_ex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_done_seen <= 1'b0;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!mem_wait && ex_mdu_valid) begin
            r_state    <= S_MDU_WAIT;
            r_wait_cnt <= '0;
          end
        end
        S_MDU_WAIT: begin
          r_wait_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == c_TMO) r_err <= 1'b1;
          if (mem_wait && mdu_done) begin
            // Result arrived while frozen; remember it for the release.
            r_done_seen <= 1'b1;
          end else if (w_release) begin
            r_done_seen <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;
  logic [CNT_W-1:0] r_perf_lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_lu    <= '0;
    end else begin
      if (w_pc_stall && (r_perf_stall != '1))    r_perf_stall <= r_perf_stall + 1'b1;
      if (w_if_id_flush && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 1'b1;
      if (w_lu_fire && (r_perf_lu != '1))        r_perf_lu    <= r_perf_lu + 1'b1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flushes      = r_perf_flush;
  assign perf_loaduse      = r_perf_lu;
`else
  // Performance counters not built.
`endif

  assign pc_stall      = w_pc_stall;
  assign if_id_stall   = w_if_id_stall;
  assign if_id_flush   = w_if_id_flush;
  assign id_ex_stall   = w_id_ex_stall;
  assign id_ex_bubble  = w_id_ex_bubble;
  assign ex_mem_stall  = w_ex_mem_stall;
  assign ex_mem_bubble = w_ex_mem_bubble;
  assign mem_wb_bubble = w_mem_wb_bubble;
  assign pc_redirect   = w_pc_redirect;
  assign mdu_start     = w_mdu_start;
  assign mdu_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Table of single-cycle RUN
//            vectors plus directed multi-cycle sequences (load-use, MDU,
//            done-under-wait, branch under wait, timeout, async reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_mdu_valid = 0;
  logic ex_branch_taken = 0, mdu_done = 0, mem_wait = 0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble;
  logic ex_mem_stall, ex_mem_bubble, mem_wb_bubble, pc_redirect, mdu_start, mdu_err;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cycles, perf_flushes, perf_loaduse;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_mdu_valid(ex_mdu_valid), .ex_branch_taken(ex_branch_taken),
    .mdu_done(mdu_done), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble),
    .ex_mem_stall(ex_mem_stall), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_bubble(mem_wb_bubble), .pc_redirect(pc_redirect),
    .mdu_start(mdu_start), .mdu_err(mdu_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_loaduse(perf_loaduse)
`endif
  );

  // Output vector order:
  // pc_stall if_id_stall if_id_flush id_ex_stall id_ex_bubble ex_mem_stall
  // ex_mem_bubble mem_wb_bubble pc_redirect mdu_start mdu_err
  localparam logic [10:0] ZERO   = 11'b000_0000_0000;
  localparam logic [10:0] FREEZE = 11'b110_1010_1000;
  localparam logic [10:0] LU     = 11'b110_0100_0000;
  localparam logic [10:0] BR     = 11'b001_0100_0100;
  localparam logic [10:0] MSTART = 11'b110_1001_0010;
  localparam logic [10:0] MSTALL = 11'b110_1001_0000;
  localparam logic [10:0] ERR    = 11'b000_0000_0001;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, ld, mdu, br, done, mw;
    logic [10:0] exp;
    string nm;
  } vec_t;

  vec_t vt[12];

  // ISA decode never produces MUL/DIV and a taken branch together.
  always @(negedge clk)
    if (!rst) assert (!(ex_mdu_valid && ex_branch_taken)) else $error("illegal stimulus: mdu+branch");

  task automatic chk(input string nm, input logic [10:0] exp);
    logic [10:0] act;
    act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
           ex_mem_stall, ex_mem_bubble, mem_wb_bubble, pc_redirect, mdu_start, mdu_err};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic ld,
                       input logic mdu, input logic br, input logic done, input logic mw);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_mdu_valid = mdu; ex_branch_taken = br;
    mdu_done = done; mem_wait = mw;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check outputs mid-cycle, then advance just past the next rising edge.
  task automatic cyc(input string nm, input logic [10:0] exp);
    @(negedge clk);
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic mdu, input logic br,
                              input logic done, input logic mw, input logic [10:0] exp);
    vec_t v;
    v.nm = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
    v.ld = ld; v.mdu = mdu; v.br = br; v.done = done; v.mw = mw; v.exp = exp;
    return v;
  endfunction

  task automatic mdu_op_simple(input string tag);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc({tag, "_start"}, MSTART);
    for (int k = 1; k <= 5; k++) cyc({tag, "_stall"}, MSTALL);
    mdu_done = 1'b1;
    cyc({tag, "_release"}, ZERO);
    idle();
    cyc({tag, "_run_idle"}, ZERO);
  endtask

  initial begin
    vt[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    vt[1]  = mk("lu_rs1",        5, 0, 1, 0, 5, 1, 0, 0, 0, 0, LU);
    vt[2]  = mk("lu_rd0",        0, 0, 1, 1, 0, 1, 0, 0, 0, 0, ZERO);
    vt[3]  = mk("lu_rs2",        1, 7, 1, 1, 7, 1, 0, 0, 0, 0, LU);
    vt[4]  = mk("lu_no_use",     9, 9, 0, 0, 9, 1, 0, 0, 0, 0, ZERO);
    vt[5]  = mk("no_load",       9, 0, 1, 0, 9, 0, 0, 0, 0, 0, ZERO);
    vt[6]  = mk("br_plus_lu",    5, 0, 1, 0, 5, 1, 0, 1, 0, 0, BR);
    vt[7]  = mk("mw_plus_lu",    5, 0, 1, 0, 5, 1, 0, 0, 0, 1, FREEZE);
    vt[8]  = mk("mw_plus_mdu",   0, 0, 0, 0, 0, 0, 1, 0, 0, 1, FREEZE);
    vt[9]  = mk("mw_plus_br",    0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FREEZE);
    vt[10] = mk("br_alone",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR);
    vt[11] = mk("done_in_run",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZERO);

    // Reset state
    idle();
    #2;
    chk("reset_outputs", ZERO);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc("after_reset", ZERO);

    // Three isolated load-use events: exactly one stall cycle each.
    for (int i = 0; i < 3; i++) begin
      drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      cyc("lu_event", LU);
      drive(5, 0, 1, 0, 6, 0, 0, 0, 0, 0);
      cyc("lu_resolved", ZERO);
    end

    // One MDU op: start + 5 waiting stalls, done on the 6th cycle releases.
    mdu_op_simple("mdu");

`ifdef HAZARD_PERF_EN
    n_cmp++;
    if (perf_loaduse !== 16'd3) begin
      n_bad++; $display("FAIL perf_loaduse: got %0d expected 3", perf_loaduse);
    end
    n_cmp++;
    if (perf_stall_cycles !== 16'd9) begin
      n_bad++; $display("FAIL perf_stall_cycles: got %0d expected 9", perf_stall_cycles);
    end
    n_cmp++;
    if (perf_flushes !== 16'd0) begin
      n_bad++; $display("FAIL perf_flushes: got %0d expected 0", perf_flushes);
    end
`endif

    // Single-cycle RUN vectors
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].rd, vt[i].ld,
            vt[i].mdu, vt[i].br, vt[i].done, vt[i].mw);
      cyc(vt[i].nm, vt[i].exp);
    end

    // MDU done while memory is stalled: release waits for mem_wait=0.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("mw_done_start", MSTART);
    cyc("mw_done_stall1", MSTALL);
    cyc("mw_done_stall2", MSTALL);
    mem_wait = 1'b1; mdu_done = 1'b1;
    cyc("mw_done_pulse", FREEZE);
    mdu_done = 1'b0;
    cyc("mw_done_frz4", FREEZE);
    cyc("mw_done_frz5", FREEZE);
    mem_wait = 1'b0;
    cyc("mw_done_release", ZERO);
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    cyc("mw_done_back_run", LU);

    // Branch held under mem_wait, redirects once memory is ready.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("br_mw_frozen", FREEZE);
    mem_wait = 1'b0;
    cyc("br_mw_redirect", BR);
    idle();
    cyc("br_mw_after", ZERO);

    // Timeout: no mdu_done for 70 wait cycles.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("tmo_start", MSTART);
    for (int k = 1; k <= 70; k++)
      cyc((k >= 65) ? "tmo_err" : "tmo_wait", (k >= 65) ? (MSTALL | ERR) : MSTALL);

    // Asynchronous reset mid-wait: outputs drop without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wait", ZERO);
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    #1;
    chk("async_rst_lu", ZERO);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("post_rst_start", MSTART);
    mdu_done = 1'b1;
    cyc("post_rst_release", ZERO);
    idle();
    cyc("post_rst_idle", ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
